pipe_stage_skid: RTL

//  Generic parametrised pipeline-stage register with valid/ready handshake, 2-entry skid buffer, flush and perf counters.

---
 rtl/pipe_stage_skid.sv | 117 +++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register with a valid/ready handshake, a 2-entry
// skid buffer, flush-to-bubble and saturating stall/bubble counters.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   flush                 discard held and incoming words, insert a bubble
//   in_valid/in_ready     upstream handshake (in_ready depends on state only)
//   in_ctrl, in_data      upstream control and datapath words
//   out_valid/out_ready   downstream handshake
//   out_ctrl, out_data    words to the next stage, taken from the main register
//   stall_cnt             cycles with out_valid=1 and out_ready=0
//   bubble_cnt            cycles with out_valid=0 and out_ready=1
module pipe_stage_skid #(
    parameter int                DATA_W      = 32,
    parameter int                CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              acc_in;
    logic              acc_out;

    // Ready and valid are pure decodes of the state register, so no
    // combinational path runs from out_ready to in_ready.
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign acc_in    = in_valid & in_ready;
    assign acc_out   = out_valid & out_ready;

    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state     <= EMPTY;
            main_ctrl <= BUBBLE_CTRL;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (acc_in) begin
                        state     <= ONE;
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end
                end
                ONE: begin
                    if (acc_in && acc_out) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end else if (acc_in) begin
                        state     <= TWO;
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                    end else if (acc_out) begin
                        // Going empty: present a harmless control word.
                        state     <= EMPTY;
                        main_ctrl <= BUBBLE_CTRL;
                    end
                end
                TWO: begin
                    if (acc_out) begin
                        state     <= ONE;
                        main_ctrl <= skid_ctrl;
                        main_data <= skid_data;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    main_ctrl <= BUBBLE_CTRL;
                    main_data <= '0;
                end
            endcase
        end
    end

    // Counters ignore flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (!out_valid && out_ready && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule
